// File: rtl/local_inject_queue_pkg.sv
// Shared NoC definitions: packet layout, route field width and route direction encoding.
package local_inject_queue_pkg;

  localparam int unsigned PACKET_SIZE = 49;
  localparam int unsigned VALID_BIT   = 48;
  localparam int unsigned TIME_HI     = 47;
  localparam int unsigned TIME_LO     = 32;
  localparam int unsigned SRC_HI      = 31;
  localparam int unsigned SRC_LO      = 16;
  localparam int unsigned DST_HI      = 15;
  localparam int unsigned DST_LO      = 0;
  localparam int unsigned ROUTE_W     = 2;

  typedef enum logic [ROUTE_W-1:0] {
    RouteLocal = 2'b00,
    RouteCw    = 2'b01,
    RouteCcw   = 2'b10
  } route_dir_e;

  function automatic logic [PACKET_SIZE-1:0] make_packet(input logic [15:0] inject_time,
                                                         input logic [15:0] src,
                                                         input logic [15:0] dst);
    return {1'b1, inject_time, src, dst};
  endfunction

endpackage

// File: rtl/local_inject_queue_sync_fifo.sv
// Synchronous FIFO with explicit pointer wrap, so any depth >= 2 is supported.
module local_inject_queue_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           din,
  output logic [Width-1:0]           dout,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is fine alongside it.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/local_inject_queue.sv
// Local injection queue: throttles the packet generator, buffers packets with route info and
// forwards them to the router's local port under credit flow control, with node statistics.
module local_inject_queue #(
  parameter int unsigned PACKET_SIZE  = local_inject_queue_pkg::PACKET_SIZE,
  parameter int unsigned ROUTE_W      = local_inject_queue_pkg::ROUTE_W,
  parameter int unsigned BUFFER_SIZE  = 4,
  parameter int unsigned CREDIT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] gen_packet,
  input  logic [ROUTE_W-1:0]     gen_route_info,
  output logic                   gen_wr_en,
  output logic [PACKET_SIZE-1:0] out_packet,
  output logic [ROUTE_W-1:0]     out_route_info,
  input  logic                   credit_in,
  output logic [63:0]            fwd_count,
  output logic [31:0]            stall_count,
  output logic                   overflow_err
);

  localparam int unsigned EntryW = PACKET_SIZE + ROUTE_W;
  localparam int unsigned CntW   = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned CrW    = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CrW-1:0] CreditMax = CrW'(CREDIT_DEPTH);
  localparam logic [CntW:0]  BufLimit  = (CntW + 1)'(BUFFER_SIZE);

  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_dout;
  logic              push_valid, push, pop, drop, credit_err;
  logic              pending_q;
  logic [CrW-1:0]    credits_q, credits_d;
  logic [CntW:0]     occupancy;

  // pending reserves the slot for the packet the generator delivers one cycle after gen_wr_en.
  assign occupancy  = {1'b0, fifo_count} + {{CntW{1'b0}}, pending_q};
  assign gen_wr_en  = ~rst & (occupancy < BufLimit);
  assign push_valid = gen_packet[PACKET_SIZE-1];
  assign pop        = ~fifo_empty & (credits_q != '0);
  assign push       = push_valid & (~fifo_full | pop);
  assign drop       = push_valid & fifo_full & ~pop;
  assign credit_err = credit_in & (credits_q == CreditMax);

  always_comb begin
    credits_d = credits_q;
    if (pop && !credit_in) begin
      credits_d = credits_q - 1'b1;
    end else if (!pop && credit_in && !credit_err) begin
      credits_d = credits_q + 1'b1;
    end
  end

  local_inject_queue_sync_fifo #(
    .Width (EntryW),
    .Depth (BUFFER_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({gen_route_info, gen_packet}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= 1'b0;
      credits_q      <= CreditMax;
      out_packet     <= '0;
      out_route_info <= '0;
      fwd_count      <= '0;
      stall_count    <= '0;
      overflow_err   <= 1'b0;
    end else begin
      pending_q <= gen_wr_en;
      credits_q <= credits_d;
      if (pop) begin
        out_packet                  <= fifo_dout[PACKET_SIZE-1:0];
        out_packet[PACKET_SIZE-1]   <= 1'b1;
        out_route_info              <= fifo_dout[EntryW-1:PACKET_SIZE];
        fwd_count                   <= fwd_count + 64'd1;
      end else begin
        out_packet     <= '0;
        out_route_info <= '0;
      end
      if (!fifo_empty && credits_q == '0 && stall_count != '1) begin
        stall_count <= stall_count + 32'd1;
      end
      if (drop || credit_err) overflow_err <= 1'b1;
    end
  end

endmodule
